// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32 fetch sequencer.
package fetch_pkg;

    typedef enum logic [2:0] {
        StBoot,
        StFetch,
        StWait,
        StHold,
        StDrain
    } fetch_state_e;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/fetch_redirect_mux.sv
// Priority select of redirect target (jump over branch); optional misalignment
// rejection when FETCH_MISALIGN_CHK_EN is defined.
module fetch_redirect_mux #(
    parameter int unsigned XLEN = 32
) (
    input  logic            i_jump,
    input  logic [XLEN-1:0] i_jump_tgt,
    input  logic            i_branch_taken,
    input  logic [XLEN-1:0] i_branch_tgt,
`ifdef FETCH_MISALIGN_CHK_EN
    output logic            o_misalign,
`endif
    output logic            o_redirect,
    output logic [XLEN-1:0] o_target
);

    logic            w_raw_req;
    logic [XLEN-1:0] w_sel;

    always_comb begin
        w_raw_req = i_jump | i_branch_taken;
        w_sel     = i_jump ? i_jump_tgt : i_branch_tgt;
`ifdef FETCH_MISALIGN_CHK_EN
        o_misalign = w_raw_req && (w_sel[1:0] != 2'b00);
        o_redirect = w_raw_req && !o_misalign;
        o_target   = w_sel;
`else
        // Without checking, low bits are simply cleared to keep the PC word aligned.
        o_redirect = w_raw_req;
        o_target   = w_sel & {{(XLEN-2){1'b1}}, 2'b00};
`endif
    end

endmodule

// File: rtl/fetch_sequencer.sv
// PC and instruction fetch control for the RV32 front end. Optional
// misalignment error output enabled by FETCH_MISALIGN_CHK_EN.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_tgt,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_tgt,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
`ifdef FETCH_MISALIGN_CHK_EN
    output logic            misalign_err,
`endif
    input  logic            decode_ready
);

    fetch_state_e    r_state, w_state_nxt;
    logic [XLEN-1:0] r_pc, w_pc_nxt;
    logic            r_instr_valid, w_instr_valid_nxt;
    logic [XLEN-1:0] r_instr, w_instr_nxt;
    logic [XLEN-1:0] r_instr_pc, w_instr_pc_nxt;
    logic            w_redirect;
    logic [XLEN-1:0] w_target;

`ifdef FETCH_MISALIGN_CHK_EN
    logic w_misalign;
    logic r_misalign_err;
`endif

    fetch_redirect_mux #(
        .XLEN (XLEN)
    ) u_redirect_mux (
        .i_jump         (jump),
        .i_jump_tgt     (jump_tgt),
        .i_branch_taken (branch_taken),
        .i_branch_tgt   (branch_tgt),
`ifdef FETCH_MISALIGN_CHK_EN
        .o_misalign     (w_misalign),
`endif
        .o_redirect     (w_redirect),
        .o_target       (w_target)
    );

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_instr_valid_nxt = r_instr_valid;
        w_instr_nxt       = r_instr;
        w_instr_pc_nxt    = r_instr_pc;

        case (r_state)
            StBoot:  w_state_nxt = StFetch;
            StFetch: w_state_nxt = StWait;
            StWait: begin
                if (imem_rvalid) begin
                    w_instr_nxt       = imem_rdata;
                    w_instr_pc_nxt    = r_pc;
                    w_instr_valid_nxt = 1'b1;
                    w_pc_nxt          = r_pc + XLEN'(PC_INC);
                    w_state_nxt       = StHold;
                end
            end
            StHold: begin
                if (decode_ready) begin
                    w_instr_valid_nxt = 1'b0;
                    w_state_nxt       = StFetch;
                end
            end
            StDrain: begin
                if (imem_rvalid) begin
                    w_state_nxt = StFetch;
                end
            end
            default: w_state_nxt = StBoot;
        endcase

        // Redirect overrides: anything in flight for the old path is dropped.
        if (w_redirect) begin
            w_pc_nxt          = w_target;
            w_instr_valid_nxt = 1'b0;
            w_instr_nxt       = r_instr;
            w_instr_pc_nxt    = r_instr_pc;
            case (r_state)
                StFetch: w_state_nxt = StDrain;
                StWait:  w_state_nxt = imem_rvalid ? StFetch : StDrain;
                StDrain: w_state_nxt = imem_rvalid ? StFetch : StDrain;
                StHold:  w_state_nxt = StFetch;
                StBoot:  w_state_nxt = StFetch;
                default: w_state_nxt = StBoot;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= StBoot;
            r_pc          <= RESET_PC;
            r_instr_valid <= 1'b0;
            r_instr       <= XLEN'(NOP);
            r_instr_pc    <= RESET_PC;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_instr_valid <= w_instr_valid_nxt;
            r_instr       <= w_instr_nxt;
            r_instr_pc    <= w_instr_pc_nxt;
        end
    end

`ifdef FETCH_MISALIGN_CHK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_misalign_err <= 1'b0;
        end else if (w_misalign) begin
            r_misalign_err <= 1'b1;
        end
    end

    assign misalign_err = r_misalign_err;
`endif

    assign imem_req    = (r_state == StFetch);
    assign imem_addr   = r_pc;
    assign instr_valid = r_instr_valid;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer; covers FETCH_MISALIGN_CHK_EN
// in either build.
module tb_fetch_sequencer;

    logic        clk;
    logic        reset;
    logic        branch_taken;
    logic [31:0] branch_tgt;
    logic        jump;
    logic [31:0] jump_tgt;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        decode_ready;
`ifdef FETCH_MISALIGN_CHK_EN
    logic        misalign_err;
`endif

    int n_cmp = 0;
    int n_err = 0;

    fetch_sequencer #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .branch_taken (branch_taken),
        .branch_tgt   (branch_tgt),
        .jump         (jump),
        .jump_tgt     (jump_tgt),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_pc     (instr_pc),
`ifdef FETCH_MISALIGN_CHK_EN
        .misalign_err (misalign_err),
`endif
        .decode_ready (decode_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Call in a FETCH cycle; returns once the word is latched (HOLD).
    task automatic serve(input int lat, input logic [31:0] data);
        step();
        repeat (lat - 1) step();
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        step();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
    endtask

    initial begin
        reset        = 1'b1;
        branch_taken = 1'b0;
        branch_tgt   = 32'h0;
        jump         = 1'b0;
        jump_tgt     = 32'h0;
        imem_rvalid  = 1'b0;
        imem_rdata   = 32'h0;
        decode_ready = 1'b1;
        step();
        step();
        chk("rst_req",   {31'b0, imem_req},    32'h0);
        chk("rst_addr",  imem_addr,            32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 32'h0);
        chk("rst_instr", instr,                32'h0000_0013);
        chk("rst_pc",    instr_pc,             32'h0);
`ifdef FETCH_MISALIGN_CHK_EN
        chk("rst_mis",   {31'b0, misalign_err}, 32'h0);
`endif

        // Release just after an edge: one BOOT cycle, then FETCH.
        reset = 1'b0;
        chk("boot_idle", {31'b0, imem_req}, 32'h0);
        step();
        chk("f0_req",  {31'b0, imem_req}, 32'h1);
        chk("f0_addr", imem_addr,         32'h0);

        serve(1, 32'h0010_0093);
        chk("i0_valid", {31'b0, instr_valid}, 32'h1);
        chk("i0_instr", instr,                32'h0010_0093);
        chk("i0_pc",    instr_pc,             32'h0);
        step();
        chk("f1_req",   {31'b0, imem_req},    32'h1);
        chk("f1_addr",  imem_addr,            32'h4);
        chk("f1_valid", {31'b0, instr_valid}, 32'h0);

        serve(1, 32'h0020_0113);
        chk("i1_pc", instr_pc, 32'h4);
        step();
        chk("f2_addr", imem_addr, 32'h8);

        // Decode stall for 5 cycles.
        decode_ready = 1'b0;
        serve(1, 32'h0030_0193);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_valid", {31'b0, instr_valid}, 32'h1);
            chk("stall_instr", instr,                32'h0030_0193);
            chk("stall_pc",    instr_pc,             32'h8);
            chk("stall_noreq", {31'b0, imem_req},    32'h0);
        end
        decode_ready = 1'b1;
        step();
        chk("resume_req",  {31'b0, imem_req}, 32'h1);
        chk("resume_addr", imem_addr,         32'hC);

        // Branch during WAIT, 3-cycle memory latency: stale word must be dropped.
        step();
        branch_taken = 1'b1;
        branch_tgt   = 32'h8;
        step();
        branch_taken = 1'b0;
        chk("drain_req",   {31'b0, imem_req},    32'h0);
        chk("drain_valid", {31'b0, instr_valid}, 32'h0);
        step();
        chk("drain_wait", {31'b0, imem_req}, 32'h0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0;
        chk("br_req",   {31'b0, imem_req},    32'h1);
        chk("br_addr",  imem_addr,            32'h8);
        chk("br_valid", {31'b0, instr_valid}, 32'h0);
        serve(1, 32'h0030_0193);
        chk("br_ipc",   instr_pc, 32'h8);
        chk("br_instr", instr,    32'h0030_0193);
        step();
        chk("f_c_addr", imem_addr, 32'hC);

        // Jump and branch together while holding; jump wins, held instr dropped.
        serve(1, 32'h0040_0213);
        decode_ready = 1'b0;
        jump         = 1'b1;
        jump_tgt     = 32'hC;
        branch_taken = 1'b1;
        branch_tgt   = 32'h8;
        step();
        jump         = 1'b0;
        branch_taken = 1'b0;
        decode_ready = 1'b1;
        chk("prio_req",   {31'b0, imem_req},    32'h1);
        chk("prio_addr",  imem_addr,            32'hC);
        chk("prio_valid", {31'b0, instr_valid}, 32'h0);

        // Jump during FETCH to the top word, then wrap.
        jump     = 1'b1;
        jump_tgt = 32'hFFFF_FFFC;
        step();
        jump = 1'b0;
        chk("jf_drain", {31'b0, imem_req}, 32'h0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1111_1111;
        step();
        imem_rvalid = 1'b0;
        chk("top_addr",  imem_addr,            32'hFFFF_FFFC);
        chk("top_valid", {31'b0, instr_valid}, 32'h0);
        serve(2, 32'h0050_0293);
        chk("top_ipc", instr_pc, 32'hFFFF_FFFC);
        step();
        chk("wrap_addr", imem_addr, 32'h0);

        // Misaligned jump target while holding the word at 0x0.
        serve(1, 32'h0060_0313);
        decode_ready = 1'b0;
        jump         = 1'b1;
        jump_tgt     = 32'h6;
        step();
        jump = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
        chk("mis_err",   {31'b0, misalign_err}, 32'h1);
        chk("mis_valid", {31'b0, instr_valid},  32'h1);
        chk("mis_ipc",   instr_pc,              32'h0);
        decode_ready = 1'b1;
        step();
        chk("mis_addr",   imem_addr,             32'h4);
        chk("mis_sticky", {31'b0, misalign_err}, 32'h1);
`else
        decode_ready = 1'b1;
        chk("mis_req",   {31'b0, imem_req},    32'h1);
        chk("mis_addr",  imem_addr,            32'h4);
        chk("mis_valid", {31'b0, instr_valid}, 32'h0);
`endif

        // Reset during WAIT; a late response in BOOT is ignored.
        step();
        reset = 1'b1;
        #1;
        chk("mid_rst_req",  {31'b0, imem_req}, 32'h0);
        chk("mid_rst_addr", imem_addr,         32'h0);
        step();
        reset       = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h2222_2222;
        step();
        imem_rvalid = 1'b0;
        chk("post_rst_req",   {31'b0, imem_req},    32'h1);
        chk("post_rst_addr",  imem_addr,            32'h0);
        chk("post_rst_valid", {31'b0, instr_valid}, 32'h0);
        chk("post_rst_instr", instr,                32'h0000_0013);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
